// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem port arbiter: func3 size codes, sequencer
// states and the registered command format.
package dmem_pkg;

  // Widths of the registered command; the top defaults its port widths to these.
  localparam int unsigned CMD_ADDR_W = 32;
  localparam int unsigned CMD_DATA_W = 32;

  // Access size codes, forwarded untouched to dmem.
  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;

  // Port ids as stored in the owner and last-grant registers.
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_t;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [2:0]            func3;
    logic                  we;
  } cmd_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant picker for the two dmem requesters.
// DMEM_ARB_RR_EN defined: round-robin on ties (the port not granted last wins).
// DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins.
module dmem_arb_pick
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

`ifdef DMEM_ARB_RR_EN
  // Single requester wins outright; on a tie, favour the port not granted last.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = (last == PORT1) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end
`else
  // The last-grant input has no meaning under fixed priority.
  logic unused_last;
  assign unused_last = last;

  // Port 0 always takes precedence.
  always_comb begin
    grant = 2'b00;
    if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter and access sequencer in front of the data memory.
// Port 0 is the pipeline MEM stage, port 1 a secondary master. The winning
// command is registered, drives dmem for one cycle, and the response is
// returned two cycles after accept. Build option: DMEM_ARB_RR_EN selects
// round-robin arbitration instead of fixed port-0 priority.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = CMD_ADDR_W,
  parameter int unsigned DATA_W = CMD_DATA_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [2:0]        p0_func3,
  input  logic              p0_we,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  output logic              p1_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [2:0]        p1_func3,
  input  logic              p1_we,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic [2:0]        mem_func3,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_sel;
  logic              owner_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [1:0]        grant;
  logic              last;
  logic              accept_en;
  logic              accept;

  // No accepts while the registered command owns the dmem port.
  assign accept_en = (state_q != StAccess);

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  // Remember which port was granted most recently; reset favours port 0 first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= PORT1;
    end else if (accept) begin
      last_q <= p1_ready;
    end
  end

  assign last = last_q;
`else
  assign last = PORT1;
`endif

  dmem_arb_pick u_pick (
    .req   ({p1_req, p0_req}),
    .last  (last),
    .grant (grant)
  );

  assign p0_ready = accept_en & grant[0];
  assign p1_ready = accept_en & grant[1];
  assign accept   = p0_ready | p1_ready;

  // Select the winner's payload for the command register.
  always_comb begin
    cmd_sel = '0;
    if (p1_ready) begin
      cmd_sel.addr  = CMD_ADDR_W'(p1_addr);
      cmd_sel.wdata = CMD_DATA_W'(p1_wdata);
      cmd_sel.func3 = p1_func3;
      cmd_sel.we    = p1_we;
    end else begin
      cmd_sel.addr  = CMD_ADDR_W'(p0_addr);
      cmd_sel.wdata = CMD_DATA_W'(p0_wdata);
      cmd_sel.func3 = p0_func3;
      cmd_sel.we    = p0_we;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept -> ACCESS -> RESP, chaining straight into ACCESS on a new accept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = accept ? StAccess : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Latch the winning command and its owner on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q   <= '0;
      owner_q <= PORT0;
    end else if (accept) begin
      cmd_q   <= cmd_sel;
      owner_q <= p1_ready;
    end
  end

  // Capture load data into the owner's read register at the end of ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == StAccess && !cmd_q.we) begin
      if (owner_q == PORT1) begin
        rdata1_q <= mem_data_out;
      end else begin
        rdata0_q <= mem_data_out;
      end
    end
  end

  // dmem drive and response outputs; enables are decoded from the state so an
  // asynchronous reset removes them immediately.
  always_comb begin
    mem_addr     = ADDR_W'(cmd_q.addr);
    mem_data_in  = DATA_W'(cmd_q.wdata);
    mem_func3    = cmd_q.func3;
    mem_wr_en    = 1'b0;
    mem_rd_en    = 1'b0;
    p0_rsp_valid = 1'b0;
    p1_rsp_valid = 1'b0;
    if (state_q == StAccess) begin
      mem_wr_en = cmd_q.we;
      mem_rd_en = !cmd_q.we;
    end
    if (state_q == StResp) begin
      p0_rsp_valid = (owner_q == PORT0);
      p1_rsp_valid = (owner_q == PORT1);
    end
  end

  assign p0_rdata = rdata0_q;
  assign p1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a small byte-addressed
// dmem model that performs func3 sizing and sign extension.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_ready, p0_we, p0_rsp_valid;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic [2:0]  p0_func3;
  logic        p1_req, p1_ready, p1_we, p1_rsp_valid;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [2:0]  p1_func3;
  logic [31:0] mem_addr, mem_data_in, mem_rdata;
  logic [2:0]  mem_func3;
  logic        mem_wr_en, mem_rd_en;

  int n_checks = 0;
  int n_pass   = 0;
  int wr_cnt   = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .p0_req       (p0_req),
    .p0_ready     (p0_ready),
    .p0_addr      (p0_addr),
    .p0_wdata     (p0_wdata),
    .p0_func3     (p0_func3),
    .p0_we        (p0_we),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rdata     (p0_rdata),
    .p1_req       (p1_req),
    .p1_ready     (p1_ready),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
    .p1_func3     (p1_func3),
    .p1_we        (p1_we),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rdata     (p1_rdata),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_func3    (mem_func3),
    .mem_wr_en    (mem_wr_en),
    .mem_rd_en    (mem_rd_en),
    .mem_data_out (mem_rdata)
  );

  // dmem model: little-endian bytes, combinational sized read.
  bit   [7:0]  mem [256];
  logic [7:0]  ma;
  logic [31:0] mw;

  always_comb begin
    ma = mem_addr[7:0];
    mw = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    case (mem_func3)
      3'b000:  mem_rdata = {{24{mw[7]}}, mw[7:0]};
      3'b001:  mem_rdata = {{16{mw[15]}}, mw[15:0]};
      3'b100:  mem_rdata = {24'h0, mw[7:0]};
      3'b101:  mem_rdata = {16'h0, mw[15:0]};
      default: mem_rdata = mw;
    endcase
  end

  always @(posedge clk) begin
    if (mem_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      case (mem_func3)
        3'b000: mem[ma] <= mem_data_in[7:0];
        3'b001: begin
          mem[ma]        <= mem_data_in[7:0];
          mem[ma + 8'd1] <= mem_data_in[15:8];
        end
        default: begin
          mem[ma]        <= mem_data_in[7:0];
          mem[ma + 8'd1] <= mem_data_in[15:8];
          mem[ma + 8'd2] <= mem_data_in[23:16];
          mem[ma + 8'd3] <= mem_data_in[31:24];
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction from an idle arbiter: accept, ACCESS, RESP.
  task automatic do_access(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, input logic we, input string tag);
    int   waited;
    logic got;
    waited = 0;
    @(negedge clk);
    if (port == 0) begin
      p0_addr = addr; p0_wdata = wdata; p0_func3 = f3; p0_we = we; p0_req = 1'b1;
    end else begin
      p1_addr = addr; p1_wdata = wdata; p1_func3 = f3; p1_we = we; p1_req = 1'b1;
    end
    #1;
    got = (port == 0) ? p0_ready : p1_ready;
    while (!got && waited < 20) begin
      @(negedge clk);
      #1;
      got = (port == 0) ? p0_ready : p1_ready;
      waited++;
    end
    check({tag, "_accept"}, {31'd0, got}, 32'd1);
    check({tag, "_wait"}, waited, 32'd0);
    @(negedge clk);
    p0_req = 1'b0;
    p1_req = 1'b0;
    #1;
    check({tag, "_acc_wr"}, {31'd0, mem_wr_en}, {31'd0, we});
    check({tag, "_acc_rd"}, {31'd0, mem_rd_en}, {31'd0, !we});
    check({tag, "_acc_addr"}, mem_addr, addr);
    check({tag, "_acc_f3"}, {29'd0, mem_func3}, {29'd0, f3});
    check({tag, "_acc_rdy"}, {30'd0, p1_ready, p0_ready}, 32'd0);
    @(negedge clk);
    #1;
    check({tag, "_rsp"}, {30'd0, p1_rsp_valid, p0_rsp_valid}, (port == 0) ? 32'd1 : 32'd2);
    check({tag, "_rsp_en"}, {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
  endtask

  initial begin
    int grants[$];
    int acc[$];
    int rsp[$];
    int both, overlap, p1_seen, c, bad;

    rst = 1'b1;
    p0_req = 0; p0_addr = 0; p0_wdata = 0; p0_func3 = 0; p0_we = 0;
    p1_req = 0; p1_addr = 0; p1_wdata = 0; p1_func3 = 0; p1_we = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_en", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
    check("rst_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_rdata0", p0_rdata, 32'd0);
    check("rst_rdata1", p1_rdata, 32'd0);
    rst = 1'b0;

    // Port 0 store word then load word.
    do_access(0, 32'h10, 32'hDEADBEEF, 3'b010, 1'b1, "p0_st");
    check("p0_st_wrcnt", wr_cnt, 32'd1);
    check("p0_st_data", mem_data_in, 32'hDEADBEEF);
    do_access(0, 32'h10, 32'h0, 3'b010, 1'b0, "p0_ld");
    check("p0_ld_wrcnt", wr_cnt, 32'd1);
    check("p0_ld_rdata", p0_rdata, 32'hDEADBEEF);
    check("p0_ld_p1rdata", p1_rdata, 32'd0);

    // Port 1 store byte then signed byte load.
    do_access(1, 32'h20, 32'h000000A5, 3'b000, 1'b1, "p1_st");
    do_access(1, 32'h20, 32'h0, 3'b000, 1'b0, "p1_ld");
    check("p1_ld_rdata", p1_rdata, 32'hFFFFFFA5);
    check("p1_ld_p0rdata", p0_rdata, 32'hDEADBEEF);

    // Both ports request continuously until 8 grants are seen.
    @(negedge clk);
    p0_addr = 32'h10; p0_func3 = 3'b010; p0_we = 1'b0; p0_req = 1'b1;
    p1_addr = 32'h20; p1_func3 = 3'b010; p1_we = 1'b0; p1_req = 1'b1;
    both = 0; overlap = 0; p1_seen = 0; c = 0;
    while (grants.size() < 8 && c < 60) begin
      #1;
      if (p0_ready && p1_ready) both++;
      if ((p0_ready || p1_ready) && (mem_rd_en || mem_wr_en)) overlap++;
      if (p1_ready) p1_seen++;
      if (p0_ready) grants.push_back(0);
      else if (p1_ready) grants.push_back(1);
      c++;
      if (grants.size() < 8 || c >= 60) @(negedge clk);
    end
    @(negedge clk);
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
    check("tie_count", grants.size(), 32'd8);
    for (int i = 0; i < grants.size(); i++) begin
`ifdef DMEM_ARB_RR_EN
      check($sformatf("tie_grant%0d", i), grants[i], i % 2);
`else
      check($sformatf("tie_grant%0d", i), grants[i], 32'd0);
`endif
    end
`ifndef DMEM_ARB_RR_EN
    check("tie_p1_starved", p1_seen, 32'd0);
`endif
    check("tie_both_rdy", both, 32'd0);
    check("tie_rdy_in_access", overlap, 32'd0);

    // Back-to-back port 0 loads with req held high.
    @(negedge clk);
    p0_addr = 32'h10; p0_func3 = 3'b010; p0_we = 1'b0; p0_req = 1'b1;
    overlap = 0;
    for (int k = 0; k <= 10; k++) begin
      #1;
      if (p0_ready) acc.push_back(k);
      if (p0_rsp_valid) rsp.push_back(k);
      if ((p0_ready || p1_ready) && (mem_rd_en || mem_wr_en)) overlap++;
      if (k == 9) p0_req = 1'b0;
      @(negedge clk);
    end
    check("b2b_acc_count", acc.size(), 32'd5);
    check("b2b_rsp_count", rsp.size(), 32'd5);
    for (int i = 0; i < acc.size() && i < 5; i++) check($sformatf("b2b_acc%0d", i), acc[i], 2 * i);
    for (int i = 0; i < rsp.size() && i < 5; i++) check($sformatf("b2b_rsp%0d", i), rsp[i], 2 * i + 2);
    check("b2b_rdy_in_access", overlap, 32'd0);
    check("b2b_rdata", p0_rdata, 32'hDEADBEEF);

    // Reset during the ACCESS cycle of a store.
    p0_addr = 32'h30; p0_wdata = 32'h12345678; p0_func3 = 3'b010; p0_we = 1'b1; p0_req = 1'b1;
    #1;
    check("rstacc_accept", {31'd0, p0_ready}, 32'd1);
    @(negedge clk);
    #1;
    check("rstacc_wr_before", {31'd0, mem_wr_en}, 32'd1);
    rst = 1'b1;
    p0_req = 1'b0;
    #1;
    check("rstacc_wr_drop", {31'd0, mem_wr_en}, 32'd0);
    @(negedge clk);
    #1;
    check("rstacc_en", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
    check("rstacc_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
    check("rstacc_rdy", {30'd0, p1_ready, p0_ready}, 32'd0);
    check("rstacc_addr", mem_addr, 32'd0);
    check("rstacc_din", mem_data_in, 32'd0);
    check("rstacc_f3", {29'd0, mem_func3}, 32'd0);
    check("rstacc_rdata0", p0_rdata, 32'd0);
    check("rstacc_rdata1", p1_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rstacc_no_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
    do_access(0, 32'h30, 32'h0, 3'b010, 1'b0, "rstacc_ld");
    check("rstacc_ld_rdata", p0_rdata, 32'd0);

    // Idle with no requests.
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (mem_wr_en || mem_rd_en || p0_ready || p1_ready || p0_rsp_valid || p1_rsp_valid) bad++;
    end
    check("idle_quiet", bad, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-port arbiter and access sequencer in front of the data memory. It shares the single dmem port between the pipeline MEM stage (port 0) and a secondary master such as a program loader or debug/DMA engine (port 1). It registers the winning command, drives dmem for exactly one cycle, and returns registered read data to the winner. The arbiter passes func3 through unchanged, so byte, half and word sizing and sign extension stay inside dmem.

## Interface
- ADDR_W, 32, address width of both ports and dmem
- DATA_W, 32, data width of both ports and dmem
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- pN_req  in  1  port N (N=0,1) request; must stay high, with payload stable, until pN_ready
- pN_ready  out  1  port N command accepted this cycle (req and ready both high)
- pN_addr  in  ADDR_W  byte address
- pN_wdata  in  DATA_W  store data
- pN_func3  in  3  access size: 000 = byte, 001 = half, 010 = word
- pN_we  in  1  1 = store, 0 = load
- pN_rsp_valid  out  1  one-cycle pulse; the access has completed
- pN_rdata  out  DATA_W  load data; valid while pN_rsp_valid is high, then held
- mem_addr  out  ADDR_W  to dmem address
- mem_data_in  out  DATA_W  to dmem data_in
- mem_func3  out  3  to dmem func3
- mem_wr_en  out  1  to dmem wr_en
- mem_rd_en  out  1  to dmem rd_en
- mem_data_out  in  DATA_W  from dmem, combinational read data

## Operation
- FSM states:
  - IDLE
  - ACCESS: the registered command drives dmem.
  - RESP: pulses the winner's rsp_valid.
- Transitions:
  - IDLE → ACCESS on any accept.
  - ACCESS → RESP always.
  - RESP → ACCESS on an accept.
  - RESP → IDLE otherwise.
- Accepts are allowed only in IDLE and RESP. In ACCESS, both readies are 0.
- Arbitration is combinational over p0_req and p1_req. At most one ready is high per cycle. A ready is never high without its req.
- On accept, the arbiter latches the command register (addr, wdata, func3, we) and the owner id.
- ACCESS drives:
  - mem_addr, mem_data_in and mem_func3 from the command register.
  - mem_wr_en = we.
  - mem_rd_en = !we.
- At the end of ACCESS, for a load, mem_data_out is captured into the owner's rdata register. The other port's rdata is untouched.
- Outside ACCESS, mem_wr_en and mem_rd_en are 0. mem_addr, mem_data_in and mem_func3 hold the command register.
- Stores also produce rsp_valid. Their rdata is unchanged.
- Payload values are not checked. An illegal func3 is forwarded as-is.

## Timing
- Accept at edge E0. ACCESS is the cycle after E0, and the dmem write commits at the end of that cycle. rsp_valid is high in the following cycle.
  - Latency: 2 cycles from accept to rsp_valid.
- Peak throughput: one access per 2 cycles. A requester that is pending during RESP is accepted in that RESP cycle.
- Simultaneous requests: resolved per Configuration. The loser waits with req held.
- A req dropped before ready is a protocol violation and has no defined effect.
- Reset values:
  - FSM = IDLE.
  - Both readies, both rsp_valids, mem_wr_en and mem_rd_en = 0.
  - mem_addr, mem_data_in, mem_func3, command register, p0_rdata and p1_rdata = 0.
  - Round-robin pointer = "port 1 last", so port 0 wins the first tie.
- Reset asserted during ACCESS: the enables drop immediately, so no write commits at the next edge and no rsp_valid is produced. The in-flight access is lost.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, the port not granted last wins.
  - The pointer updates on every accept.
  - A single requester always wins.
- DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins.
  - No pointer flop exists.
  - Port 1 may starve while port 0 requests continuously.

## Structure
- Shared package dmem_pkg holds:
  - func3 constants F3_BYTE, F3_HALF, F3_WORD.
  - The FSM state enum.
  - A command struct {addr, wdata, func3, we}.
- One sub-module: dmem_arb_pick. It is combinational: reqs plus last pointer in, one-hot grant out, and it contains the macro-dependent logic.
- Instantiate once in the top, between the MEM stage and dmem.

## Test plan
- p0 store word 0xDEADBEEF to 0x10, then p0 load word from 0x10:
  - Each ready is high for 1 cycle.
  - mem_wr_en is high for exactly 1 cycle.
  - p0_rsp_valid is high 2 cycles after each accept.
  - p0_rdata = 0xDEADBEEF.
  - p1_rdata stays 0.
- p1 store byte 0xA5 to 0x20, then p1 load byte from 0x20:
  - mem_func3 = 000 in both ACCESS cycles.
  - p1_rdata = 0xFFFFFFA5 after dmem sign extension.
- p0 and p1 both request continuously for 8 accesses:
  - With the RR macro, grants alternate 0,1,0,1… starting with 0.
  - Without it, all 8 go to p0 and p1_ready never rises.
- Back-to-back p0 loads with req held high:
  - Accepts occur every 2 cycles.
  - rsp_valid pulses are separated by 2 cycles.
  - Readies are never high in an ACCESS cycle.
- Assert rst during the ACCESS cycle of a store of 0x12345678 to 0x30, holding it over the next rising edge:
  - mem_wr_en drops at once.
  - No rsp_valid is produced.
  - A following load of 0x30 does not return 0x12345678.
  - All outputs are at their reset values.
- Idle for 10 cycles with no reqs:
  - mem_wr_en and mem_rd_en stay 0.
  - Both readies and both rsp_valids stay 0.
